// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out stream converter.
// Imported by both the shift core and the streaming top.
package piso_pkg;

    localparam int DATA_WIDTH_MIN = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit counter width for a word of w bits; a counter always needs at least one bit.
    function automatic int cnt_width(input int w);
        return (w < DATA_WIDTH_MIN) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Shift register plus bit counter for one word in flight.
// Load has priority over advance. MSB_FIRST selects which end is presented and the shift direction.
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  adv,
    output logic                  out_bit,
    output logic                  last
);

    localparam int            CW       = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;

    // Zeros are shifted in, so a fully drained word leaves the register clear.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = load_data;
            bit_cnt_d = '0;
        end else if (adv) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shreg_d = {1'b0, shreg_q[DATA_WIDTH-1:1]};
            end
            bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign out_bit = MSB_FIRST ? shreg_q[DATA_WIDTH-1] : shreg_q[0];
    assign last    = (bit_cnt_q == CNT_LAST);

endmodule

// File: rtl/piso_stream.sv
// Word-in / bit-out converter with a one-word holding buffer so consecutive words stream without gaps.
// The FSM decides when the shift core loads, and whether the data comes from the hold buffer or the input.
module piso_stream
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  ser_en,
    output logic                  ser_out,
    output logic                  ser_valid,
    output logic                  ser_last
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_valid_q, hold_valid_d;

    logic                  accept;
    logic                  boundary;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  adv;
    logic                  core_bit;
    logic                  core_last;

    assign in_ready = !hold_valid_q;
    assign accept   = in_valid && in_ready;
    assign boundary = (state_q == SHIFT) && ser_en && core_last;

    // At a boundary the held word goes first. A word accepted in that same cycle bypasses the hold register.
    // If there is nothing to load, the last advance leaves the core empty.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;
        load_data    = in_data;
        adv          = (state_q == SHIFT) && ser_en;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (boundary) begin
                    if (hold_valid_q) begin
                        load         = 1'b1;
                        load_data    = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    hold_d       = in_data;
                    hold_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    piso_shift_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_data(load_data),
        .adv      (adv),
        .out_bit  (core_bit),
        .last     (core_last)
    );

    assign ser_valid = (state_q == SHIFT);
    assign ser_out   = core_bit;
    assign ser_last  = ser_valid && core_last;

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out converter with a valid/ready word input, a one-word holding buffer for gapless back-to-back streaming, selectable bit order and a serial-side stall. It is the next generation of the fixed 8-bit PISO. It sits between a core's word-wide output and a one-bit link serializer on the ring interface, and is clocked by the single core clock.

## Interface
- DATA_WIDTH, 8: word width in bits; legal range ≥ 2.
- MSB_FIRST, 1: 1 = bit DATA_WIDTH-1 is shifted out first; 0 = bit 0 first.
- clk  input  1  single clock; all flops sample on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  parallel word; sampled on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_en  input  1  serial-side advance enable; 0 = stall.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a valid bit.
- ser_last  output  1  ser_out is the final bit of its word.

## Operation
- **Accept.** A word is accepted on a rising edge where in_valid && in_ready.
- **in_ready.** in_ready = !hold_valid, driven combinationally from a register.
- **Shifter states.** IDLE and SHIFT.
- **IDLE.**
  - An accepted word loads straight into the shift register.
  - bit_cnt is set to 0 and the state moves to SHIFT.
  - The hold register stays empty.
- **SHIFT, ser_en = 1.**
  - ser_out advances one bit.
  - bit_cnt increments.
- **SHIFT, ser_en = 0.** Shift register, bit_cnt, ser_out and ser_last are frozen. ser_valid stays 1.
- **SHIFT, word accepted.** The word goes to the hold register and hold_valid is set.
- **Word boundary.** Applies when bit_cnt == DATA_WIDTH-1 and ser_en = 1. The next load source, in priority order:
  1. The hold register, if hold_valid. hold_valid is cleared.
  2. The input word, if accepted this same cycle. It bypasses the hold register.
  3. None: the state moves to IDLE.
- **Outputs.**
  - ser_out = shreg[DATA_WIDTH-1] when MSB_FIRST = 1; otherwise shreg[0].
  - The shift direction follows MSB_FIRST.
  - ser_valid = (state == SHIFT).
  - ser_last = ser_valid && bit_cnt == DATA_WIDTH-1.
- **Counter.** bit_cnt is $clog2(DATA_WIDTH) bits wide and wraps to 0 on every load. It never exceeds DATA_WIDTH-1.
- **Ordering.** Words are emitted strictly in acceptance order. None is dropped or duplicated.

## Timing
- **Reset values.** On reset low, asynchronously:
  - state = IDLE, hold_valid = 0, shreg = 0, bit_cnt = 0.
  - Outputs: ser_out = 0, ser_valid = 0, ser_last = 0, in_ready = 1.
- **Reset mid-word.** Discards the partial word and the held word immediately.
- **Latency.** An accept at edge N gives the first bit with ser_valid = 1 after edge N, i.e. in cycle N+1.
- **Word duration.** With ser_en held high, a word occupies exactly DATA_WIDTH cycles.
- **Throughput.** Back-to-back words produce DATA_WIDTH×k consecutive ser_valid cycles with no gap, provided each next word is accepted no later than the boundary cycle.
- **Full buffer.** With hold full and the shifter busy, in_ready = 0. in_ready rises in the cycle after the boundary edge that drains hold.
- **Simultaneous events.** A boundary plus an accept in IDLE→SHIFT timing is handled by the bypass above. An accept while hold is full cannot occur because in_ready = 0.
- **Stall at the last bit.** With ser_en = 0, ser_last stays high until the boundary edge actually occurs.

## Structure
- **Package piso_pkg:**
  - state enum {IDLE, SHIFT};
  - cnt_width function wrapping $clog2;
  - localparam DATA_WIDTH_MIN = 2.
- **Sub-module piso_shift_core:**
  - contents: shift register, bit_cnt, load/shift muxing, MSB_FIRST direction;
  - ports: load, load_data, adv;
  - outputs: bit, last.
- **Top piso_stream:** owns the FSM, the hold register and the handshake.

## Test plan
- **MSB-first order.** DATA_WIDTH = 8, MSB_FIRST = 1; accept 8'hE9 → ser_out 1,1,1,0,1,0,0,1 on 8 consecutive cycles. ser_last is high only on the 8th bit. ser_valid starts the cycle after accept.
- **LSB-first order.** MSB_FIRST = 0; accept 8'hE9 → 1,0,0,1,0,1,1,1.
- **Back-to-back with hold.** Present 8'hE9 then 8'h5A with in_valid held high → 16 contiguous ser_valid cycles. in_ready drops while hold is full and returns after the first boundary. The second word serializes as 0,1,0,1,1,0,1,0.
- **Stall.** Deassert ser_en for 3 cycles after bit 3 of 8'hE9 → ser_out is frozen at 0 and the remaining bits are unchanged. The word spans 11 cycles.
- **Reset mid-word.** Pull reset low after bit 4 with a word in hold → all outputs are 0 and in_ready is 1 immediately. After release and a new word 8'hFF, only 1s are emitted.
- **Wide word.** DATA_WIDTH = 12, MSB_FIRST = 1, accept 12'hA5C → 1010_0101_1100. ser_last is on the 12th bit.
